// File: rtl/mtrx_serializer.sv
// rtl/mtrx_serializer.sv - captures a packed matrix and streams its elements one per handshake
module mtrx_serializer #(
    parameter int ELEM_W = 8,
    parameter int N_ELEM = 25
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load,
    input  logic [ELEM_W*N_ELEM-1:0] matrix,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [ELEM_W-1:0]        out_data,
    output logic [4:0]               out_index,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam logic [4:0] LAST_IDX = 5'(N_ELEM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [4:0]                 cnt_q, cnt_d;
    logic [ELEM_W*N_ELEM-1:0]   buf_q, buf_d;
    logic [ELEM_W-1:0]          elem_sel;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    buf_d   = matrix;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Element mux written as a compare loop so the index never runs past the buffer
    always_comb begin
        elem_sel = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            if (cnt_q == 5'(i)) begin
                elem_sel = buf_q[i*ELEM_W +: ELEM_W];
            end
        end
    end

    always_comb begin
        out_valid = (state_q == SEND);
        out_data  = out_valid ? elem_sel : '0;
        out_index = out_valid ? cnt_q : '0;
        out_last  = out_valid && (cnt_q == LAST_IDX);
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
    end

endmodule

// File: tb/tb_mtrx_serializer.sv
// tb/tb_mtrx_serializer.sv - directed self-checking bench for mtrx_serializer
module tb_mtrx_serializer;

    localparam int ELEM_W = 8;
    localparam int N_ELEM = 25;
    localparam int MW     = ELEM_W * N_ELEM;

    logic              clock;
    logic              reset;
    logic              load;
    logic [MW-1:0]     matrix;
    logic              out_ready;
    logic              out_valid;
    logic [ELEM_W-1:0] out_data;
    logic [4:0]        out_index;
    logic              out_last;
    logic              busy;
    logic              done;

    int n_run;
    int n_fail;
    logic [7:0] exp_q [N_ELEM];

    mtrx_serializer #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) dut (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .matrix    (matrix),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MW-1:0] mk_seq();
        logic [MW-1:0] m;
        for (int i = 0; i < N_ELEM; i++) m[i*ELEM_W +: ELEM_W] = 8'(i + 1);
        return m;
    endfunction

    function automatic logic [MW-1:0] mk_fill(input logic [7:0] v);
        logic [MW-1:0] m;
        for (int i = 0; i < N_ELEM; i++) m[i*ELEM_W +: ELEM_W] = v;
        return m;
    endfunction

    task automatic set_exp_seq();
        for (int i = 0; i < N_ELEM; i++) exp_q[i] = 8'(i + 1);
    endtask

    task automatic set_exp_fill(input logic [7:0] v);
        for (int i = 0; i < N_ELEM; i++) exp_q[i] = v;
    endtask

    task automatic chk_beat(input string tag, input int i);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"},  out_data, exp_q[i]);
        chk({tag, "_index"}, out_index, i);
        chk({tag, "_last"},  out_last, (i == N_ELEM - 1) ? 1 : 0);
        chk({tag, "_done"},  done, 0);
    endtask

    task automatic chk_idle_outs(input string tag, input logic exp_busy, input logic exp_done);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"},  out_data, 0);
        chk({tag, "_index"}, out_index, 0);
        chk({tag, "_last"},  out_last, 0);
        chk({tag, "_busy"},  busy, exp_busy);
        chk({tag, "_done"},  done, exp_done);
    endtask

    // Streams the whole presented matrix with out_ready=1; optionally pulses a junk load mid-stream
    task automatic stream_full(input string tag, input int junk_at);
        out_ready = 1'b1;
        for (int i = 0; i < N_ELEM; i++) begin
            if (i == junk_at) begin
                load   = 1'b1;
                matrix = mk_fill(8'hFF);
            end else begin
                load = 1'b0;
            end
            chk_beat(tag, i);
            tick();
        end
        load = 1'b0;
        chk_idle_outs({tag, "_donecyc"}, 1'b1, 1'b1);
        tick();
        chk_idle_outs({tag, "_after"}, 1'b0, 1'b0);
    endtask

    initial begin
        int e;
        int cyc;
        n_run     = 0;
        n_fail    = 0;
        reset     = 1'b0;
        load      = 1'b0;
        out_ready = 1'b0;
        matrix    = '0;
        tick();
        tick();
        chk_idle_outs("reset", 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        chk_idle_outs("idle", 1'b0, 1'b0);

        // Basic stream
        set_exp_seq();
        matrix = mk_seq();
        load   = 1'b1;
        tick();
        chk("basic_busy", busy, 1);
        stream_full("basic", -1);

        // Backpressure: ready pattern 1,0,0 repeating
        matrix = mk_seq();
        load   = 1'b1;
        tick();
        load = 1'b0;
        e    = 0;
        cyc  = 0;
        while (e < N_ELEM && cyc < 200) begin
            out_ready = (cyc % 3 == 0);
            chk_beat("bp", e);
            tick();
            if (out_ready) e++;
            cyc++;
        end
        chk("bp_count", e, N_ELEM);
        chk_idle_outs("bp_donecyc", 1'b1, 1'b1);
        tick();
        chk_idle_outs("bp_after", 1'b0, 1'b0);

        // Load while busy is ignored
        matrix = mk_seq();
        load   = 1'b1;
        tick();
        stream_full("ldbusy", 7);
        matrix = mk_seq();
        load   = 1'b1;
        tick();
        stream_full("ldlast", N_ELEM - 1);

        // Input change after load
        matrix = mk_seq();
        load   = 1'b1;
        tick();
        load   = 1'b0;
        matrix = '0;
        stream_full("inchg", -1);

        // Reset mid-stream after index 10 transfers
        matrix    = mk_seq();
        load      = 1'b1;
        out_ready = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            chk_beat("rst", i);
            tick();
        end
        chk("rst_idx11", out_index, 11);
        reset = 1'b0;
        tick();
        chk_idle_outs("rst_abort", 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        chk_idle_outs("rst_nodone", 1'b0, 1'b0);
        set_exp_fill(8'd26);
        matrix = mk_fill(8'd26);
        load   = 1'b1;
        tick();
        stream_full("rst26", -1);

        // Back-to-back with load held high
        set_exp_seq();
        matrix    = mk_seq();
        load      = 1'b1;
        out_ready = 1'b1;
        tick();
        matrix = mk_fill(8'd26);
        for (int i = 0; i < N_ELEM; i++) begin
            chk_beat("b2b", i);
            tick();
        end
        chk_idle_outs("b2b_donecyc", 1'b1, 1'b1);
        tick();
        chk_idle_outs("b2b_idle", 1'b0, 1'b0);
        tick();
        set_exp_fill(8'd26);
        stream_full("b2b2", -1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/mtrx_serializer.md
MTRX_SERIALIZER -- requirements
Module: mtrx_serializer

Interface
REQ-001 Parameter ELEM_W, default 8, width in bits of one matrix element.
REQ-002 Parameter N_ELEM, default 25, number of elements per matrix (5x5).
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-005 load  input  1  request to capture a matrix; accepted only when the block is idle.
REQ-006 matrix  input  ELEM_W*N_ELEM  packed matrix; element i occupies bits [i*ELEM_W +: ELEM_W].
REQ-007 out_ready  input  1  downstream consumer can accept an element this cycle.
REQ-008 out_valid  output  1  out_data/out_index/out_last hold a valid element.
REQ-009 out_data  output  ELEM_W  current element value.
REQ-010 out_index  output  5  index of the current element, 0..N_ELEM-1.
REQ-011 out_last  output  1  high with out_valid when out_index equals N_ELEM-1.
REQ-012 busy  output  1  high in SEND and DONE states.
REQ-013 done  output  1  one-cycle pulse after the final element transfers.

Function
REQ-014 The block SHALL implement three states: IDLE, SEND, DONE.
REQ-015 IDLE: when load=1 at a rising edge, the block SHALL register matrix into an internal buffer, set the element counter to 0 and enter SEND.
REQ-016 Latency: out_valid SHALL be high in the cycle immediately after the edge that accepted load, presenting element 0.
REQ-017 A transfer SHALL occur on any rising edge where out_valid=1 and out_ready=1.
REQ-018 While out_valid=1 and out_ready=0, out_data, out_index and out_last SHALL remain stable.
REQ-019 On a transfer with out_index<N_ELEM-1, the counter SHALL increment by 1; the next element SHALL be presented in the following cycle with no bubble.
REQ-020 On the transfer of element N_ELEM-1, the block SHALL enter DONE; out_valid SHALL be 0 and done SHALL be 1 for exactly that one cycle; the next state SHALL be IDLE.
REQ-021 With out_ready held at 1, a full matrix SHALL take exactly N_ELEM cycles of out_valid=1, followed by one cycle of done=1.
REQ-022 load SHALL be ignored in SEND and DONE; the buffer SHALL not change, and matrix SHALL not be sampled.
REQ-023 The buffer contents SHALL not be affected by changes on matrix after the load edge.
REQ-024 out_data SHALL be taken unmodified from the buffer; no arithmetic is performed on elements.
REQ-025 out_valid SHALL be 0 in IDLE and DONE; out_data, out_index and out_last SHALL be 0 whenever out_valid=0.
REQ-026 Back-to-back matrices: load asserted in the cycle where done=1 SHALL be ignored; load in the next cycle (IDLE) SHALL be accepted.

Reset
REQ-027 When reset=0 at a rising edge, the state SHALL become IDLE, and the counter and buffer SHALL become 0; out_valid, out_data, out_index, out_last, busy and done SHALL all be 0.
REQ-028 reset=0 during SEND or DONE SHALL abort the transfer; no done pulse SHALL be issued, and the buffered matrix SHALL be discarded.
REQ-029 reset SHALL take priority over load and out_ready on the same edge.

Verification
REQ-030 Basic: element i = i+1 (1..25), load pulse, out_ready=1 -> 25 consecutive beats, out_data 1..25, out_index 0..24, out_last only on index 24, done=1 on the cycle after, then busy=0.
REQ-031 Backpressure: same matrix, out_ready toggling 1,0,0,1,... -> values stable while stalled, every element delivered exactly once in order, done after element 25.
REQ-032 Load while busy: pulse load with an all-0xFF matrix during SEND -> ignored; original 1..25 sequence completes unchanged.
REQ-033 Input change after load: drive matrix to all-0x00 one cycle after the accepted load -> output is still 1..25.
REQ-034 Reset mid-stream: reset=0 after index 10 transfers -> next cycle all outputs 0, no done pulse; a new load of all-26 matrix streams twenty-five 26s.
REQ-035 Back-to-back: load held high continuously -> second matrix starts exactly 2 cycles after done-cycle start (DONE, then IDLE accept), first beat in the cycle after acceptance.
